systolic_collector: RTL and testbench

Downstream stage of the systolic PE array in the Chebyshev interpolation filter. It watches the `outputword` buses of all PEs and mirrors the PEs' slot counter and word index. At each slot boundary it captures the one PE whose 8-term accumulation has just completed, then streams the results in order through a small FIFO with a valid/ready handshake.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_collector_if.sv | 13 +
 rtl/systolic_collector_sync_fifo.sv | 73 +++++++
 rtl/systolic_collector.sv | 78 +++++++
 tb/tb_systolic_collector.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared sizing and result type for the Chebyshev interpolation PE array and its collector.
package systolic_pkg;

   localparam int WORDLENGTH = 16;
   localparam int NUM_PE     = 8;
   localparam int IDX_W      = $clog2(NUM_PE);

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      idx_t                  idx;
      logic [WORDLENGTH-1:0] word;
   } result_t;

   function automatic idx_t next_idx(input idx_t cur);
      return cur + idx_t'(1);
   endfunction

endpackage

// File: rtl/systolic_collector_if.sv
// Result stream of the collector: valid/ready handshake carrying {index, word}.
interface systolic_collector_if #(
   parameter int WORDLENGTH = systolic_pkg::WORDLENGTH,
   parameter int IDX_W      = systolic_pkg::IDX_W
);
   logic                  out_valid;
   logic                  out_ready;
   logic [WORDLENGTH-1:0] out_word;
   logic [IDX_W-1:0]      out_index;

   modport master (output out_valid, output out_word, output out_index, input out_ready);
   modport slave  (input out_valid, input out_word, input out_index, output out_ready);
endinterface

// File: rtl/systolic_collector_sync_fifo.sv
// Synchronous FIFO whose head entry is held in output registers; a push into an
// empty FIFO is written to storage and shows up on the head one cycle later.
module sync_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic             clk30x,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
   logic [AW:0]      cnt_r, cnt_kept_s, cnt_nxt_s;
   logic             do_push_s, do_pop_s;
   logic             head_valid_r;
   logic [WIDTH-1:0] head_data_r, head_nxt_s;

   // Occupancy flags, accepted push/pop and the entry that becomes head next cycle.
   always_comb begin
      full         = (cnt_r == (AW+1)'(DEPTH));
      empty        = (cnt_r == (AW+1)'(0));
      do_pop_s     = pop && !empty;
      do_push_s    = push && (!full || do_pop_s);
      cnt_kept_s   = cnt_r - (AW+1)'(do_pop_s);
      cnt_nxt_s    = cnt_kept_s + (AW+1)'(do_push_s);
      rd_ptr_nxt_s = rd_ptr_r + AW'(do_pop_s);
      if (cnt_kept_s == (AW+1)'(0)) begin
         head_nxt_s = din;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage array, written on every accepted push.
   always_ff @(posedge clk30x) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers, count and registered head.
   always_ff @(posedge clk30x) begin
      if (reset) begin
         wr_ptr_r     <= AW'(0);
         rd_ptr_r     <= AW'(0);
         cnt_r        <= (AW+1)'(0);
         head_valid_r <= 1'b0;
         head_data_r  <= WIDTH'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r     <= rd_ptr_nxt_s;
         cnt_r        <= cnt_nxt_s;
         head_valid_r <= (cnt_nxt_s != (AW+1)'(0));
         if (cnt_nxt_s != (AW+1)'(0)) begin
            head_data_r <= head_nxt_s;
         end
      end
   end

   assign head_valid = head_valid_r;
   assign head_data  = head_data_r;

endmodule

// File: rtl/systolic_collector.sv
// Collects each PE's finished 8-term sum at its slot boundary and streams it out
// in PE order through a small FIFO.
module systolic_collector #(
   parameter int WORDLENGTH = systolic_pkg::WORDLENGTH,
   parameter int NUM_PE     = systolic_pkg::NUM_PE,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk30x,
   input  logic                         reset,
   input  logic [NUM_PE*WORDLENGTH-1:0] pe_words,
   input  logic [31:0]                  timing,
   systolic_collector_if.master         res,
   output logic                         overflow
);
   localparam int                SEL_W    = $clog2(NUM_PE);
   localparam logic [SEL_W-1:0]  WARM_MAX = SEL_W'(NUM_PE - 1);

   logic [31:0]                 count_r;
   logic [SEL_W-1:0]            word_idx_r, warm_r, cap_idx_s;
   logic [WORDLENGTH-1:0]       cap_word_s;
   logic                        boundary_s, capture_s, pop_s;
   logic                        fifo_full_s, fifo_empty_s, head_valid_s;
   logic                        overflow_r;
   logic [SEL_W+WORDLENGTH-1:0] head_s;

   // Boundary detect and selection of the PE whose accumulation just completed.
   always_comb begin
      boundary_s = (count_r == timing);
      cap_idx_s  = word_idx_r + SEL_W'(1);
      cap_word_s = pe_words[int'(cap_idx_s)*WORDLENGTH +: WORDLENGTH];
      capture_s  = boundary_s && (warm_r == WARM_MAX);
      pop_s      = !fifo_empty_s && res.out_ready;
   end

   // Slot counter replica, warm-up saturation and sticky overflow.
   always_ff @(posedge clk30x) begin
      if (reset) begin
         count_r    <= 32'hFFFF_FFFF;
         word_idx_r <= SEL_W'(0);
         warm_r     <= SEL_W'(0);
         overflow_r <= 1'b0;
      end else begin
         if (boundary_s) begin
            count_r    <= 32'd0;
            word_idx_r <= cap_idx_s;
            if (warm_r != WARM_MAX) begin
               warm_r <= warm_r + SEL_W'(1);
            end
         end else begin
            count_r <= count_r + 32'd1;
         end
         if (capture_s && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (SEL_W + WORDLENGTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk30x     (clk30x),
      .reset      (reset),
      .push       (capture_s),
      .din        ({cap_idx_s, cap_word_s}),
      .pop        (pop_s),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s),
      .head_valid (head_valid_s),
      .head_data  (head_s)
   );

   assign res.out_valid = head_valid_s;
   assign res.out_index = head_s[WORDLENGTH +: SEL_W];
   assign res.out_word  = head_s[WORDLENGTH-1:0];
   assign overflow      = overflow_r;

endmodule

// File: tb/tb_systolic_collector.sv
// Self-checking bench for systolic_collector: randomized PE words and back-pressure
// against a slot-arithmetic and queue reference model.
module tb_systolic_collector;
   import systolic_pkg::*;

   localparam int DEPTH = 4;

   logic                         clk30x = 1'b0;
   logic                         reset  = 1'b1;
   logic [NUM_PE*WORDLENGTH-1:0] pe_words = '0;
   logic [31:0]                  timing = 32'd3;
   logic                         overflow;

   systolic_collector_if bus ();

   systolic_collector #(
      .WORDLENGTH (WORDLENGTH),
      .NUM_PE     (NUM_PE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk30x   (clk30x),
      .reset    (reset),
      .pe_words (pe_words),
      .timing   (timing),
      .res      (bus),
      .overflow (overflow)
   );

   always #5 clk30x = ~clk30x;

   int      n_cmp = 0;
   int      n_bad = 0;
   result_t q[$];
   bit      m_ovf = 1'b0;
   int      m_n   = 0;

   // One clock edge; the model consumes the inputs that were present at that edge.
   task automatic step();
      bit                           rdy, rst, pop, push;
      int                           k, t;
      result_t                      r;
      logic [NUM_PE*WORDLENGTH-1:0] w;
      rst = reset; rdy = bus.out_ready; w = pe_words; t = int'(timing);
      @(posedge clk30x);
      #1;
      if (rst) begin
         q.delete(); m_ovf = 1'b0; m_n = 0;
      end else begin
         m_n++;
         pop  = (q.size() > 0) && rdy;
         push = 1'b0;
         if (m_n >= t + 2 && (m_n - t - 2) % (t + 1) == 0) begin
            k = (m_n - t - 2) / (t + 1) + 1;
            if (k >= NUM_PE) begin
               push   = 1'b1;
               r.idx  = idx_t'(k % NUM_PE);
               r.word = w[(k % NUM_PE)*WORDLENGTH +: WORDLENGTH];
            end
         end
         if (pop) void'(q.pop_front());
         if (push) begin
            if (q.size() < DEPTH) q.push_back(r);
            else m_ovf = 1'b1;
         end
      end
   endtask

   function automatic logic [20:0] exp_vec();
      return {q.size() > 0, m_ovf, (q.size() > 0) ? q[0] : 19'h0};
   endfunction

   function automatic logic [20:0] obs_vec();
      return {bus.out_valid, overflow, bus.out_valid ? {bus.out_index, bus.out_word} : 19'h0};
   endfunction

   task automatic rand_words();
      for (int p = 0; p < NUM_PE; p++) pe_words[p*WORDLENGTH +: WORDLENGTH] = 16'($urandom);
   endtask

   task automatic apply_reset(input logic [31:0] tmg);
      reset = 1'b1; timing = tmg;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      reset = 1'b1;
      repeat (3) step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.out_word !== 16'h0) begin n_bad++; $display("FAIL reset_word got=%h exp=0", bus.out_word); end
      n_cmp++; if (bus.out_index !== 3'd0) begin n_bad++; $display("FAIL reset_index got=%0d exp=0", bus.out_index); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_basic();
      int first_cyc;
      logic [18:0] first_res;
      first_cyc = 0; first_res = 19'h0;
      for (int p = 0; p < NUM_PE; p++) pe_words[p*WORDLENGTH +: WORDLENGTH] = 16'h0100 + 16'(p);
      bus.out_ready = 1'b1;
      apply_reset(32'd3);
      for (int i = 0; i < 80; i++) begin
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL basic cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
         if (bus.out_valid === 1'b1 && first_cyc == 0) begin
            first_cyc = m_n; first_res = {bus.out_index, bus.out_word};
         end
      end
      n_cmp++; if (first_cyc != 33) begin n_bad++; $display("FAIL basic_first_cycle got=%0d exp=33", first_cyc); end
      n_cmp++; if (first_res !== {3'd0, 16'h0100}) begin n_bad++; $display("FAIL basic_first_result got=%h exp=%h", first_res, {3'd0, 16'h0100}); end
   endtask

   task automatic test_one_cycle_slots();
      bus.out_ready = 1'b1;
      apply_reset(32'd0);
      for (int i = 0; i < 60; i++) begin
         rand_words();
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL one_cycle cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL one_cycle_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b1;
      apply_reset(32'd2);
      for (int i = 0; i < 24; i++) begin rand_words(); step(); end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         rand_words();
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL backpressure_ovf got=%b exp=1", overflow); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_words();
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL drain cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      end
   endtask

   task automatic test_full_pop_same_cycle();
      int guard;
      bus.out_ready = 1'b0;
      apply_reset(32'd2);
      guard = 0;
      while (q.size() < DEPTH && guard < 80) begin
         rand_words(); step(); guard++;
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL fill cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      end
      n_cmp++; if (guard >= 80) begin n_bad++; $display("FAIL fill_timeout got=%0d exp=<80", guard); end
      while ((m_n + 1 - 4) % 3 != 0) begin rand_words(); step(); end
      bus.out_ready = 1'b1;
      rand_words();
      step();
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_pop_ovf got=%b exp=0", overflow); end
      n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL full_pop cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      bus.out_ready = 1'b0;
      repeat (2) begin rand_words(); step(); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         rand_words();
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
      end
   endtask

   task automatic test_mid_reset();
      int guard, first_cyc;
      bus.out_ready = 1'b0;
      apply_reset(32'd3);
      guard = 0;
      while (q.size() < 2 && guard < 80) begin rand_words(); step(); guard++; end
      n_cmp++; if (guard >= 80) begin n_bad++; $display("FAIL queue2_timeout got=%0d exp=<80", guard); end
      apply_reset(32'd3);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ovf got=%b exp=0", overflow); end
      bus.out_ready = 1'b1;
      first_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         rand_words();
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
         if (bus.out_valid === 1'b1 && first_cyc == 0) first_cyc = m_n;
      end
      n_cmp++; if (first_cyc != 33) begin n_bad++; $display("FAIL mid_reset_first got=%0d exp=33", first_cyc); end
   endtask

   task automatic test_negative();
      for (int p = 0; p < NUM_PE; p++) pe_words[p*WORDLENGTH +: WORDLENGTH] = 16'h8001;
      bus.out_ready = 1'b1;
      apply_reset(32'd1);
      for (int i = 0; i < 30; i++) begin
         step();
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL negative cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
         if (bus.out_valid === 1'b1) begin
            n_cmp++; if (bus.out_word !== 16'h8001) begin n_bad++; $display("FAIL negative_word got=%h exp=8001", bus.out_word); end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         apply_reset(32'($urandom_range(0, 4)));
         for (int i = 0; i < 120; i++) begin
            rand_words();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", m_n, obs_vec(), exp_vec()); end
         end
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_one_cycle_slots();
      test_backpressure();
      test_full_pop_same_cycle();
      test_mid_reset();
      test_negative();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
